// File: rtl/ccff_bitstream_loader_pkg.sv
// ccff_pkg: shared states and CRC-16-CCITT helpers for the configuration-chain loader
package ccff_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, FINISH, ROTATE} state_t;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    return {crc[14:0], 1'b0} ^ ({16{crc[15] ^ b}} & CRC16_POLY);
  endfunction
endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// ccff_cfg_if: valid/ready bitstream word channel from the programming interface
interface ccff_cfg_if #(parameter int WORD_W = 32);
  logic [WORD_W-1:0] data;
  logic valid;
  logic ready;
  modport master(output data, valid, input ready);
  modport slave(input data, valid, output ready);
endinterface

// File: rtl/ccff_bitstream_loader_crc16.sv
// ccff_crc16_serial: bit-serial CRC-16-CCITT accumulator with synchronous clear
module ccff_crc16_serial
  import ccff_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clear,
  input  logic        din,
  output logic [15:0] crc
);
  always_ff @(posedge clk)
    if (rst || clear) crc <= CRC16_INIT;
    else if (en) crc <= crc16_step(crc, din);
endmodule

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: serializes bitstream words LSB-first into the CLB config chain.
// CCFF_READBACK_EN adds a rotate-back pass with CRC comparison of head vs tail streams.
module ccff_bitstream_loader
  import ccff_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W = $clog2(CHAIN_LEN + 1)
) (
  input  logic      prog_clk,
  input  logic      prog_reset,
  input  logic      start,
  ccff_cfg_if.slave cfg,
  output logic      ccff_head,
  output logic      ccff_shift_en,
  input  logic      ccff_tail,
  output logic      busy,
  output logic      done,
  output logic      crc_ok
);
  localparam int WB_W = $clog2(WORD_W + 1);
  state_t state, nxt;
  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt, left;
  logic [WB_W-1:0] rem, take;
  logic head_q, shift_q, last, fin;
  assign left = CNT_W'(CHAIN_LEN) - bit_cnt;
  assign take = (int'(left) > WORD_W) ? WB_W'(WORD_W) : WB_W'(left);
  assign last = bit_cnt == CNT_W'(CHAIN_LEN - 1);
  assign busy = state != IDLE;
  assign cfg.ready = state == FETCH;
`ifdef CCFF_READBACK_EN
  logic [15:0] crc_h, crc_t;
  assign fin = state == ROTATE && last;
  assign ccff_head = state == ROTATE ? ccff_tail : head_q;
  assign ccff_shift_en = shift_q | (state == ROTATE);
  ccff_crc16_serial u_crc_h (
    .clk(prog_clk), .rst(prog_reset), .en(state == SHIFT), .clear(state == IDLE && start),
    .din(shreg[0]), .crc(crc_h)
  );
  ccff_crc16_serial u_crc_t (
    .clk(prog_clk), .rst(prog_reset), .en(state == ROTATE), .clear(state == IDLE && start),
    .din(ccff_tail), .crc(crc_t)
  );
  // the tail CRC register lags by the bit arriving on this final edge
  always_ff @(posedge prog_clk)
    if (prog_reset || (state == IDLE && start)) crc_ok <= 1'b0;
    else if (fin) crc_ok <= crc_h == crc16_step(crc_t, ccff_tail);
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign fin = state == FINISH;
  assign ccff_head = head_q;
  assign ccff_shift_en = shift_q;
  assign crc_ok = 1'b0;
`endif
  always_ff @(posedge prog_clk) state <= prog_reset ? IDLE : nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:   nxt = start ? FETCH : IDLE;
      FETCH:  nxt = cfg.valid ? SHIFT : FETCH;
      SHIFT:  nxt = rem == WB_W'(1) ? (last ? FINISH : FETCH) : SHIFT;
`ifdef CCFF_READBACK_EN
      FINISH: nxt = ROTATE;
      ROTATE: nxt = last ? IDLE : ROTATE;
`else
      FINISH: nxt = IDLE;
`endif
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge prog_clk)
    if (prog_reset) begin
      shreg <= '0;
      bit_cnt <= '0;
      rem <= '0;
      head_q <= 1'b0;
      shift_q <= 1'b0;
      done <= 1'b0;
    end else begin
      shift_q <= state == SHIFT;
      done <= fin;
      if (state == IDLE && start) bit_cnt <= '0;
      if (state == FETCH && cfg.valid) begin
        shreg <= cfg.data;
        rem <= take;
      end
      if (state == SHIFT) begin
        head_q <= shreg[0];
        shreg <= shreg >> 1;
        bit_cnt <= bit_cnt + CNT_W'(1);
        rem <= rem - WB_W'(1);
      end
`ifdef CCFF_READBACK_EN
      if (state == FINISH) bit_cnt <= '0;
      if (state == ROTATE) bit_cnt <= bit_cnt + CNT_W'(1);
`endif
    end
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb_ccff_bitstream_loader: randomized loads against a chain model and bit-order reference
module tb_ccff_bitstream_loader;
  localparam int W = 32;
  localparam int N = 40;
  localparam int NW = (N + W - 1) / W;
`ifdef CCFF_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  localparam int ES = N * (1 + RB);
  localparam int EB = ES + NW + 1;

  logic clk = 0, rst = 1, start = 0;
  logic head, sen, tail, busy, done, crc_ok;
  ccff_cfg_if #(.WORD_W(W)) cfg ();
  ccff_bitstream_loader #(.WORD_W(W), .CHAIN_LEN(N)) dut (
    .prog_clk(clk), .prog_reset(rst), .start(start), .cfg(cfg),
    .ccff_head(head), .ccff_shift_en(sen), .ccff_tail(tail),
    .busy(busy), .done(done), .crc_ok(crc_ok)
  );
  always #5 clk = ~clk;

  logic [N-1:0] chain = '0;
  int stuck = -1;
  int n_shift = 0, n_done = 0, n_busy = 0;
  logic tails[$];
  int checks = 0, errors = 0, to = 0, gap_sen = 0, bad_ready = 0;
  logic [W-1:0] wd[NW];
  assign tail = chain[0];

  // physical chain: head enters the far end, tail is bit 0
  always @(posedge clk) begin
    logic [N-1:0] c;
    if (sen) begin
      c = {head, chain[N-1:1]};
      if (stuck >= 0) c[stuck] = 1'b0;
      chain <= c;
      tails.push_back(tail);
      n_shift++;
    end
    if (busy) n_busy++;
    if (done) n_done++;
  end

  function automatic logic [N-1:0] expect_chain();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = wd[i / W][i % W];
    return v;
  endfunction

  function automatic logic [15:0] crc_bits(input logic [N-1:0] v);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < N; i++) c = {c[14:0], 1'b0} ^ ((c[15] ^ v[i]) ? 16'h1021 : 16'h0000);
    return c;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) to++;
    @(negedge clk);
  endtask

  task automatic drive_load(input int stall, input bit midstart, input bit extra);
    int n;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    for (int k = 0; k < NW; k++) begin
      n = 0;
      while (!cfg.ready && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (n >= 500) to++;
      if (k > 0) repeat (stall) begin
        @(negedge clk);
        gap_sen += int'(sen);
      end
      cfg.valid = 1;
      cfg.data = wd[k];
      @(negedge clk);
      cfg.valid = 0;
      cfg.data = $urandom;
      if (midstart && k == 0) begin
        repeat (5) @(negedge clk);
        start = 1;
        @(negedge clk) start = 0;
      end
    end
    if (extra) begin
      cfg.valid = 1;
      n = 0;
      while (busy && n < 2000) begin
        if (cfg.ready) bad_ready++;
        @(negedge clk);
        n++;
      end
      cfg.valid = 0;
    end
    wait_idle();
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (cfg.ready !== 0) begin errors++; $display("FAIL reset_ready got %b exp 0", cfg.ready); end
    checks++; if (sen !== 0 || head !== 0) begin errors++; $display("FAIL reset_chain_io got sen=%b head=%b exp 0", sen, head); end
    checks++; if (done !== 0 || crc_ok !== 0) begin errors++; $display("FAIL reset_done_crc got %b/%b exp 0/0", done, crc_ok); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    int bs = n_shift, bd = n_done, bb = n_busy;
    wd[0] = 32'hA5A5_0F0F;
    wd[1] = 32'h0000_00C3;
    drive_load(0, 0, 0);
    checks++; if (chain !== 40'hC3_A5A5_0F0F) begin errors++; $display("FAIL nominal_chain got %h exp c3a5a50f0f", chain); end
    checks++; if (n_shift - bs !== ES) begin errors++; $display("FAIL nominal_shifts got %0d exp %0d", n_shift - bs, ES); end
    checks++; if (n_done - bd !== 1) begin errors++; $display("FAIL nominal_done got %0d exp 1", n_done - bd); end
    checks++; if (n_busy - bb !== EB) begin errors++; $display("FAIL nominal_busy_cycles got %0d exp %0d", n_busy - bb, EB); end
    checks++; if (crc_ok !== 1'(RB)) begin errors++; $display("FAIL nominal_crc_ok got %b exp %0d", crc_ok, RB); end
  endtask

  task automatic test_backpressure();
    int bs = n_shift, bb = n_busy;
    gap_sen = 0;
    wd[0] = 32'hA5A5_0F0F;
    wd[1] = 32'h0000_00C3;
    drive_load(7, 0, 0);
    checks++; if (gap_sen !== 0) begin errors++; $display("FAIL stall_shift_en got %0d exp 0", gap_sen); end
    checks++; if (chain !== 40'hC3_A5A5_0F0F) begin errors++; $display("FAIL stall_chain got %h exp c3a5a50f0f", chain); end
    checks++; if (n_shift - bs !== ES) begin errors++; $display("FAIL stall_shifts got %0d exp %0d", n_shift - bs, ES); end
    checks++; if (n_busy - bb !== EB + 7) begin errors++; $display("FAIL stall_busy_cycles got %0d exp %0d", n_busy - bb, EB + 7); end
  endtask

  task automatic test_random();
    int bs, bd, bb, s;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NW; k++) wd[k] = $urandom;
      s = $urandom_range(0, 5);
      bs = n_shift; bd = n_done; bb = n_busy; gap_sen = 0;
      drive_load(s, 0, 0);
      checks++; if (chain !== expect_chain()) begin errors++; $display("FAIL rand%0d_chain got %h exp %h", r, chain, expect_chain()); end
      checks++; if (n_shift - bs !== ES || gap_sen !== 0) begin errors++; $display("FAIL rand%0d_shifts got %0d gap %0d exp %0d gap 0", r, n_shift - bs, gap_sen, ES); end
      checks++; if (n_done - bd !== 1) begin errors++; $display("FAIL rand%0d_done got %0d exp 1", r, n_done - bd); end
      checks++; if (n_busy - bb !== EB + s) begin errors++; $display("FAIL rand%0d_busy got %0d exp %0d", r, n_busy - bb, EB + s); end
    end
  endtask

  task automatic test_ignored();
    int bs = n_shift, bd = n_done, bb = n_busy;
    for (int k = 0; k < NW; k++) wd[k] = $urandom;
    bad_ready = 0;
    drive_load(0, 1, 1);
    checks++; if (bad_ready !== 0) begin errors++; $display("FAIL extra_ready got %0d exp 0", bad_ready); end
    checks++; if (chain !== expect_chain()) begin errors++; $display("FAIL ignored_chain got %h exp %h", chain, expect_chain()); end
    checks++; if (n_shift - bs !== ES) begin errors++; $display("FAIL ignored_shifts got %0d exp %0d", n_shift - bs, ES); end
    checks++; if (n_done - bd !== 1) begin errors++; $display("FAIL ignored_done got %0d exp 1", n_done - bd); end
    checks++; if (n_busy - bb !== EB) begin errors++; $display("FAIL ignored_busy got %0d exp %0d", n_busy - bb, EB); end
  endtask

  task automatic test_reset_mid();
    int bs = n_shift, bd, n = 0;
    wd[0] = $urandom;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    cfg.valid = 1;
    cfg.data = wd[0];
    @(negedge clk) cfg.valid = 0;
    while (n_shift - bs < 17 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 200) begin errors++; $display("FAIL rstmid_reach got %0d exp 17", n_shift - bs); end
    bd = n_done;
    rst = 1;
    @(negedge clk);
    checks++; if (busy !== 0 || sen !== 0 || done !== 0) begin errors++; $display("FAIL rstmid_outputs got busy=%b sen=%b done=%b exp 0", busy, sen, done); end
    rst = 0;
    repeat (5) @(negedge clk);
    checks++; if (n_done - bd !== 0 || busy !== 0) begin errors++; $display("FAIL rstmid_no_done got %0d busy %b exp 0", n_done - bd, busy); end
    bs = n_shift;
    bd = n_done;
    for (int k = 0; k < NW; k++) wd[k] = $urandom;
    drive_load(0, 0, 0);
    checks++; if (chain !== expect_chain()) begin errors++; $display("FAIL rstmid_reload got %h exp %h", chain, expect_chain()); end
    checks++; if (n_shift - bs !== ES || n_done - bd !== 1) begin errors++; $display("FAIL rstmid_reload_cnt got %0d/%0d exp %0d/1", n_shift - bs, n_done - bd, ES); end
  endtask

`ifdef CCFF_READBACK_EN
  task automatic test_readback(input bit fault);
    int bs = n_shift, bd = n_done;
    logic [N-1:0] rt;
    logic exp_ok;
    for (int k = 0; k < NW; k++) wd[k] = $urandom;
    if (fault) stuck = $urandom_range(0, N - 1);
    drive_load(0, 0, 0);
    for (int j = 0; j < N; j++) rt[j] = tails[bs + N + j];
    exp_ok = crc_bits(expect_chain()) == crc_bits(rt);
    if (!fault) exp_ok = 1'b1;
    checks++; if (n_shift - bs !== 2 * N) begin errors++; $display("FAIL rb%0d_shifts got %0d exp %0d", fault, n_shift - bs, 2 * N); end
    checks++; if (crc_ok !== exp_ok) begin errors++; $display("FAIL rb%0d_crc_ok got %b exp %b", fault, crc_ok, exp_ok); end
    checks++; if (n_done - bd !== 1) begin errors++; $display("FAIL rb%0d_done got %0d exp 1", fault, n_done - bd); end
    if (!fault) begin
      checks++; if (chain !== expect_chain() || rt !== expect_chain()) begin errors++; $display("FAIL rb_chain got %h tail %h exp %h", chain, rt, expect_chain()); end
    end
    stuck = -1;
  endtask
`endif

  initial begin
    cfg.valid = 0;
    cfg.data = '0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_random();
    test_ignored();
    test_reset_mid();
`ifdef CCFF_READBACK_EN
    test_readback(0);
    test_readback(1);
    test_readback(0);
`endif
    checks++; if (to !== 0) begin errors++; $display("FAIL timeouts got %0d exp 0", to); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Configuration-chain driver that sits directly upstream of the CLB tile array.
- Accepts bitstream words from the programming interface over a valid/ready handshake and serializes them LSB-first onto the chain head pin (ccff_head of the first tile).
- Generates the per-bit shift enable for the prog_clk gating cell.
- Returns a completion pulse once the full chain length has been shifted.

Parameters:
- WORD_W, 32, width of one bitstream word.
- CHAIN_LEN, 1024, total configuration bits in the chain (>=1).
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter.

Ports:
- prog_clk  input  1  programming clock; all state is rising-edge on this clock.
- prog_reset  input  1  reset; synchronous, active-high.
- start  input  1  one-cycle pulse; begins a load. Ignored unless IDLE.
- cfg_data  input  WORD_W  bitstream word; bit 0 is shifted first.
- cfg_valid  input  1  cfg_data is valid.
- cfg_ready  output  1  loader accepts cfg_data this cycle.
- ccff_head  output  1  serial data to the chain head.
- ccff_shift_en  output  1  chain captures ccff_head on this prog_clk edge.
- ccff_tail  input  1  serial data from the chain tail (last tile ccff_tail).
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the load completes.
- crc_ok  output  1  readback CRC matched; sticky until the next start (see Optional Feature).

Behaviour:
Reset:
- prog_reset is synchronous and active-high, sampled on prog_clk.
- Reset forces state IDLE, cfg_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, crc_ok=0, counters=0.
- Reset mid-load aborts immediately: no done pulse, and the chain contents are undefined.

States and transitions:
- IDLE: on start, go to FETCH; bit_cnt=0; crc_ok clears.
- FETCH:
  - cfg_ready=1.
  - On cfg_valid&cfg_ready, latch the word into shreg, set word_bits=min(WORD_W, CHAIN_LEN-bit_cnt), go to SHIFT.
  - cfg_valid low means stall: ccff_shift_en stays 0.
- SHIFT:
  - Each cycle: ccff_head<=shreg[0], ccff_shift_en<=1, shreg>>=1, bit_cnt++.
  - After word_bits bits: if bit_cnt==CHAIN_LEN go to FINISH, else go to FETCH.
  - Upper bits of a partial final word are discarded.
- FINISH: drive ccff_shift_en<=0, done<=1 for exactly one cycle, then return to IDLE (or go to ROTATE if the optional feature is enabled).

Timing rules:
- ccff_head and ccff_shift_en are registered and change together.
- The chain captures on the edge after they are driven.
- Exactly CHAIN_LEN cycles have ccff_shift_en=1 per load.
- No bubble beyond the FETCH cycle: each word costs word_bits+1 cycles.
- Host must supply ceil(CHAIN_LEN/WORD_W) words; extra words are not accepted (cfg_ready=0 outside FETCH).

Other rules:
- start while busy is ignored.
- cfg_valid is not required to hold once accepted.

Optional Feature:
Macro: CCFF_READBACK_EN.
- Defined:
  - A bit-serial CRC-16-CCITT (poly 0x1021, init 0xFFFF) accumulates every shifted head bit.
  - After the load, state ROTATE runs CHAIN_LEN cycles with ccff_shift_en=1 and ccff_head driven combinationally from ccff_tail, so the chain rotates back to its loaded contents.
  - A second CRC accumulates ccff_tail over those cycles.
  - At the end, crc_ok=1 if the two CRCs are equal, else 0. done pulses after ROTATE instead of after FINISH.
- Undefined: no CRC logic or ROTATE state; crc_ok is tied 0; done pulses at FINISH.

Decomposition:
- Shared package ccff_pkg holds:
  - state enum: IDLE, FETCH, SHIFT, FINISH, ROTATE;
  - CRC16_POLY=16'h1021 and CRC16_INIT=16'hFFFF;
  - function crc16_step(crc, bit).
- Natural sub-module: ccff_crc16_serial (enable, bit in, clear, 16-bit crc out), instantiated twice when CCFF_READBACK_EN is defined.

Test Plan:
- Nominal load: CHAIN_LEN=40, WORD_W=32, words 0xA5A5_0F0F then 0x0000_00C3 -> 40 shift_en cycles; model chain holds bits 0x0F0F,0xA5A5,0xC3 in LSB-first order; upper 24 bits of word 2 are dropped; one done pulse.
- Backpressure: cfg_valid low for 7 cycles between words -> ccff_shift_en=0 throughout the gap; final chain contents unchanged from the nominal case.
- Ignored inputs: start asserted mid-SHIFT and extra cfg_valid after the last word -> no restart, cfg_ready stays 0, exactly one done pulse.
- Reset mid-load: prog_reset high at bit 17 -> next cycle busy=0, ccff_shift_en=0, no done; a following fresh start loads correctly.
- Readback pass (CCFF_READBACK_EN defined): 40-bit chain model -> 80 total shift_en cycles, crc_ok=1, chain contents equal the loaded value.
- Readback fail (CCFF_READBACK_EN defined): chain model with one stuck-at-0 flop -> crc_ok=0, done still pulses once.
